// File: rtl/dcache_dptw_rd_responder.sv
// DCache-side responder for the data-MMU page-table-walker read port.
// Looks up one PTE doubleword, refilling and retrying on a miss, then pulses Done.
`ifndef DATA_TYPE__LEN
`define DATA_TYPE__LEN 3
`endif
`ifndef DATA_TYPE_D
`define DATA_TYPE_D 3'd3
`endif

module dcache_dptw_rd_responder #(
  parameter int PADDR_WIDTH = 56,
  parameter int LINE_BYTES  = 64,
  parameter int MAX_RETRY   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       DCache_RdReq_DPTW_Valid,
  input  logic [PADDR_WIDTH-1:0]     DCache_RdReq_DPTW_Paddr,
  input  logic [`DATA_TYPE__LEN-1:0] DCache_RdReq_DPTW_DataType,
  output logic [63:0]                DCache_RdResp_DPTW_Data,
  output logic                       DCache_RdResp_DPTW_Done,
  output logic                       DCache_RdResp_DPTW_Error,
  input  logic                       ptw_abort,
  output logic                       lk_req,
  output logic [PADDR_WIDTH-1:0]     lk_paddr,
  input  logic                       lk_gnt,
  input  logic                       lk_resp_valid,
  input  logic                       lk_resp_hit,
  input  logic [63:0]                lk_resp_data,
  output logic                       refill_req,
  output logic [PADDR_WIDTH-1:0]     refill_paddr,
  input  logic                       refill_ack,
  input  logic                       refill_done,
  input  logic                       refill_err
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0]     MAX_RETRY_C = RETRY_W'(MAX_RETRY);
  localparam logic [PADDR_WIDTH-1:0] LINE_MASK   = PADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LK_REQ  = 3'd1,
    LK_WAIT = 3'd2,
    RF_REQ  = 3'd3,
    RF_WAIT = 3'd4,
    RESP    = 3'd5,
    RELEASE = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [PADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [63:0]            data_q, data_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      retry_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      retry_q <= retry_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Abort is checked ahead of every other transition so it also beats a same-cycle hit.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    retry_d = retry_q;
    data_d  = data_q;
    err_d   = err_q;
    if (ptw_abort && state_q != IDLE && state_q != RELEASE) begin
      state_d = RELEASE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (DCache_RdReq_DPTW_Valid && !ptw_abort) begin
            addr_d  = DCache_RdReq_DPTW_Paddr;
            retry_d = '0;
            data_d  = '0;
            if (DCache_RdReq_DPTW_Paddr[2:0] != 3'b000 ||
                DCache_RdReq_DPTW_DataType != `DATA_TYPE_D) begin
              err_d   = 1'b1;
              state_d = RESP;
            end else begin
              err_d   = 1'b0;
              state_d = LK_REQ;
            end
          end
        end
        LK_REQ: if (lk_gnt) state_d = LK_WAIT;
        LK_WAIT: begin
          if (lk_resp_valid) begin
            if (lk_resp_hit) begin
              data_d  = lk_resp_data;
              state_d = RESP;
            end else if (retry_q < MAX_RETRY_C) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = RF_REQ;
            end else begin
              err_d   = 1'b1;
              state_d = RESP;
            end
          end
        end
        RF_REQ: if (refill_ack) state_d = RF_WAIT;
        RF_WAIT: begin
          if (refill_done) begin
            if (refill_err) begin
              err_d   = 1'b1;
              state_d = RESP;
            end else begin
              state_d = LK_REQ;
            end
          end
        end
        RESP:    state_d = RELEASE;
        RELEASE: if (!DCache_RdReq_DPTW_Valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign lk_req                   = (state_q == LK_REQ);
  assign lk_paddr                 = lk_req ? addr_q : '0;
  assign refill_req               = (state_q == RF_REQ);
  assign refill_paddr             = refill_req ? (addr_q & ~LINE_MASK) : '0;
  assign DCache_RdResp_DPTW_Done  = (state_q == RESP);
  assign DCache_RdResp_DPTW_Error = DCache_RdResp_DPTW_Done && err_q;
  assign DCache_RdResp_DPTW_Data  = DCache_RdResp_DPTW_Done ? data_q : 64'd0;

endmodule
